nmi_post_wbuf: RTL and testbench

- Posted write buffer between a user core's NMI master port and the SoC NMI fabric.
- Upstream writes are acknowledged as soon as they are queued in a FIFO, so CPU store latency is hidden.
- Reads are strictly ordered behind all queued writes, then forwarded downstream.
- Sits directly downstream of the core wrapper's NMI master, clocked on the core clock.

---
 rtl/nmi_post_wbuf.sv | 148 ++++++++++++++
 tb/tb_nmi_post_wbuf.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nmi_post_wbuf.sv
// Posted write buffer between a core NMI master and the SoC NMI fabric; reads are ordered behind queued writes.
// Optional macro NMI_POST_WBUF_STAT_EN adds stat_wr_o / stat_stall_o counters.
module nmi_post_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   s_nmi_valid_i,
  output logic                   s_nmi_ready_o,
  input  logic [AW-1:0]          s_nmi_addr_i,
  input  logic [31:0]            s_nmi_wdata_i,
  input  logic [3:0]             s_nmi_wstrb_i,
  output logic [31:0]            s_nmi_rdata_o,
  output logic                   m_nmi_valid_o,
  input  logic                   m_nmi_ready_i,
  output logic [AW-1:0]          m_nmi_addr_o,
  output logic [31:0]            m_nmi_wdata_o,
  output logic [3:0]             m_nmi_wstrb_o,
  input  logic [31:0]            m_nmi_rdata_i,
  output logic                   idle_o,
  output logic [$clog2(DEPTH):0] level_o
`ifdef NMI_POST_WBUF_STAT_EN
  ,
  output logic [31:0]            stat_wr_o,
  output logic [31:0]            stat_stall_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, R_REQ, RESP} rd_state_t;
  typedef enum logic {D_IDLE, D_REQ} dr_state_t;

  rd_state_t       r_rd_state, w_rd_next;
  dr_state_t       r_dr_state, w_dr_next;

  logic [AW-1:0]   r_mem_addr  [DEPTH];
  logic [31:0]     r_mem_wdata [DEPTH];
  logic [3:0]      r_mem_wstrb [DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [LW-1:0]   r_level;
  logic            r_wr_ack;
  logic [31:0]     r_rdata;

  logic            w_is_write, w_is_read, w_full, w_empty;
  logic            w_push, w_pop, w_stall;

  assign w_is_write = s_nmi_valid_i & (|s_nmi_wstrb_i);
  assign w_is_read  = s_nmi_valid_i & (s_nmi_wstrb_i == 4'd0);
  assign w_full     = (r_level == LW'(DEPTH));
  assign w_empty    = (r_level == '0);

  // The ready term keeps a held request from being pushed twice.
  assign s_nmi_ready_o = r_wr_ack | (r_rd_state == RESP);
  assign w_push  = w_is_write & ~s_nmi_ready_o & (r_rd_state == IDLE) & ~w_full;
  assign w_pop   = (r_dr_state == D_REQ) & m_nmi_ready_i;
  assign w_stall = w_is_write & ~s_nmi_ready_o & (r_rd_state == IDLE) & w_full;

  assign s_nmi_rdata_o = r_rdata;
  assign level_o       = r_level;
  assign idle_o        = w_empty & (r_dr_state == D_IDLE) & (r_rd_state == IDLE);

  always_comb begin
    w_rd_next     = r_rd_state;
    w_dr_next     = r_dr_state;
    m_nmi_valid_o = 1'b0;
    m_nmi_addr_o  = '0;
    m_nmi_wdata_o = '0;
    m_nmi_wstrb_o = '0;

    unique case (r_rd_state)
      IDLE:    if (w_is_read && !s_nmi_ready_o) w_rd_next = WAIT;
      WAIT:    if (w_empty && r_dr_state == D_IDLE) w_rd_next = R_REQ;
      R_REQ:   if (m_nmi_ready_i) w_rd_next = RESP;
      RESP:    w_rd_next = IDLE;
      default: w_rd_next = IDLE;
    endcase

    unique case (r_dr_state)
      D_IDLE:  if (!w_empty && r_rd_state != R_REQ) w_dr_next = D_REQ;
      D_REQ:   if (m_nmi_ready_i) w_dr_next = D_IDLE;
      default: w_dr_next = D_IDLE;
    endcase

    // Drain and read requests are mutually exclusive: a read only issues on an empty FIFO.
    if (r_dr_state == D_REQ) begin
      m_nmi_valid_o = 1'b1;
      m_nmi_addr_o  = r_mem_addr[r_rptr];
      m_nmi_wdata_o = r_mem_wdata[r_rptr];
      m_nmi_wstrb_o = r_mem_wstrb[r_rptr];
    end else if (r_rd_state == R_REQ) begin
      m_nmi_valid_o = 1'b1;
      m_nmi_addr_o  = s_nmi_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_addr[r_wptr]  <= s_nmi_addr_i;
      r_mem_wdata[r_wptr] <= s_nmi_wdata_i;
      r_mem_wstrb[r_wptr] <= s_nmi_wstrb_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_state <= IDLE;
      r_dr_state <= D_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_wr_ack   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      r_dr_state <= w_dr_next;
      r_wr_ack   <= w_push;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (r_rd_state == R_REQ && m_nmi_ready_i) r_rdata <= m_nmi_rdata_i;
    end
  end

`ifdef NMI_POST_WBUF_STAT_EN
  logic [31:0] r_stat_wr, r_stat_stall;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stat_wr    <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_push)  r_stat_wr    <= r_stat_wr + 32'd1;
      if (w_stall) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_wr_o    = r_stat_wr;
  assign stat_stall_o = r_stat_stall;
`endif

endmodule

// File: tb/tb_nmi_post_wbuf.sv
// Directed self-checking bench for nmi_post_wbuf (DEPTH=4); acts as the core master and the fabric slave.
// Stat counter checks are compiled in when NMI_POST_WBUF_STAT_EN is defined.
module tb_nmi_post_wbuf;

  logic        clk = 1'b0;
  logic        rstN;
  logic        sValid, sReady, mValid, mReady, idle;
  logic [31:0] sAddr, sWdata, sRdata, mAddr, mWdata, mRdata;
  logic [3:0]  sWstrb, mWstrb;
  logic [2:0]  level;
`ifdef NMI_POST_WBUF_STAT_EN
  logic [31:0] statWr, statStall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nmi_post_wbuf #(.DEPTH(4), .AW(32)) dut (
    .clk_i         (clk),
    .rst_n_i       (rstN),
    .s_nmi_valid_i (sValid),
    .s_nmi_ready_o (sReady),
    .s_nmi_addr_i  (sAddr),
    .s_nmi_wdata_i (sWdata),
    .s_nmi_wstrb_i (sWstrb),
    .s_nmi_rdata_o (sRdata),
    .m_nmi_valid_o (mValid),
    .m_nmi_ready_i (mReady),
    .m_nmi_addr_o  (mAddr),
    .m_nmi_wdata_o (mWdata),
    .m_nmi_wstrb_o (mWstrb),
    .m_nmi_rdata_i (mRdata),
    .idle_o        (idle),
    .level_o       (level)
`ifdef NMI_POST_WBUF_STAT_EN
    ,
    .stat_wr_o     (statWr),
    .stat_stall_o  (statStall)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    sValid = 1'b1; sAddr = a; sWdata = d; sWstrb = s;
  endtask

  task automatic drop_req();
    sValid = 1'b0; sAddr = '0; sWdata = '0; sWstrb = '0;
  endtask

  task automatic do_reset();
    rstN = 1'b0; drop_req(); mReady = 1'b0; mRdata = '0;
    tick(); tick();
    rstN = 1'b1;
    tick();
  endtask

  // Bounded wait for the upstream ready pulse; returns cycles since the request was presented.
  task automatic wait_ack(input string name, output int waited);
    waited = 0;
    while (sReady !== 1'b1 && waited < 30) begin
      tick();
      waited++;
    end
    checks++;
    if (sReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s: no s_nmi ready after %0d cycles", name, waited);
    end
  endtask

  // Fabric side: wait for a downstream request, compare it, accept it with zero added latency.
  task automatic serve_one(input string name, input logic [31:0] ea, input logic [31:0] ed,
                           input logic [3:0] es, input logic [31:0] rd);
    int n = 0;
    while (mValid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (mValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s: no m_nmi valid after %0d cycles", name, n);
    end else if ({mAddr, mWdata, mWstrb} !== {ea, ed, es}) begin
      errors++;
      $display("[TB] FAIL %s: got addr=%h wdata=%h wstrb=%h, expected addr=%h wdata=%h wstrb=%h",
               name, mAddr, mWdata, mWstrb, ea, ed, es);
    end
    mReady = 1'b1; mRdata = rd;
    tick();
    mReady = 1'b0; mRdata = '0;
  endtask

  task automatic test_reset();
    rstN = 1'b0; drop_req(); mReady = 1'b0; mRdata = '0;
    tick();
    checks++;
    if ({sReady, sRdata, mValid, mAddr, mWdata, mWstrb} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got sReady=%b sRdata=%h mValid=%b mAddr=%h, expected all zero",
               sReady, sRdata, mValid, mAddr);
    end
    checks++;
    if (level !== 3'd0 || idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_level_idle: got level=%0d idle=%b, expected level=0 idle=1", level, idle);
    end
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    drive_req(32'h0300_0000, 32'hDEAD_BEEF, 4'hF);
    tick();
    checks++;
    if (sReady !== 1'b1 || mValid !== 1'b0 || level !== 3'd1) begin
      errors++;
      $display("[TB] FAIL single_ack: got sReady=%b mValid=%b level=%0d, expected 1 0 1", sReady, mValid, level);
    end
    tick();
    drop_req();
    checks++;
    if (sReady !== 1'b0 || level !== 3'd1) begin
      errors++;
      $display("[TB] FAIL single_no_double_push: got sReady=%b level=%0d, expected 0 1", sReady, level);
    end
    checks++;
    if ({mValid, mAddr, mWdata, mWstrb} !== {1'b1, 32'h0300_0000, 32'hDEAD_BEEF, 4'hF}) begin
      errors++;
      $display("[TB] FAIL single_downstream: got v=%b addr=%h wdata=%h wstrb=%h, expected 1 03000000 deadbeef f",
               mValid, mAddr, mWdata, mWstrb);
    end
    tick(); tick(); tick();
    checks++;
    if (mValid !== 1'b1 || level !== 3'd1 || idle !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_hold: got mValid=%b level=%0d idle=%b, expected 1 1 0", mValid, level, idle);
    end
    mReady = 1'b1;
    tick();
    mReady = 1'b0;
    checks++;
    if (mValid !== 1'b0 || level !== 3'd0 || idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_done: got mValid=%b level=%0d idle=%b, expected 0 0 1", mValid, level, idle);
    end
  endtask

  task automatic test_fill();
    logic [31:0] addrs [5];
    logic [31:0] datas [5];
    int waited;
    for (int k = 0; k < 5; k++) begin
      addrs[k] = 32'h0300_0100 + 32'(k * 4);
      datas[k] = 32'hA000_0000 + 32'(k);
    end
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_req(addrs[k], datas[k], 4'hF);
      wait_ack("fill_ack", waited);
      checks++;
      if (waited !== 1) begin
        errors++;
        $display("[TB] FAIL fill_ack_latency: write %0d acked after %0d cycles, expected 1", k, waited);
      end
      tick();
    end
    drive_req(addrs[4], datas[4], 4'hF);
    checks++;
    if (level !== 3'd4 || sReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_full: got level=%0d sReady=%b, expected 4 0", level, sReady);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (sReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fill_stall: got sReady=%b on stall cycle %0d, expected 0", sReady, c);
      end
    end
    checks++;
    if (mValid !== 1'b1 || mAddr !== addrs[0]) begin
      errors++;
      $display("[TB] FAIL fill_head: got mValid=%b mAddr=%h, expected 1 %h", mValid, mAddr, addrs[0]);
    end
    mReady = 1'b1;
    tick();
    mReady = 1'b0;
    checks++;
    if (sReady !== 1'b0 || level !== 3'd3) begin
      errors++;
      $display("[TB] FAIL fill_after_pop: got sReady=%b level=%0d, expected 0 3", sReady, level);
    end
    tick();
    checks++;
    if (sReady !== 1'b1 || level !== 3'd4) begin
      errors++;
      $display("[TB] FAIL fill_fifth_ack: got sReady=%b level=%0d, expected 1 4", sReady, level);
    end
`ifdef NMI_POST_WBUF_STAT_EN
    checks++;
    if (statWr !== 32'd5 || statStall !== 32'd3) begin
      errors++;
      $display("[TB] FAIL fill_stats: got wr=%0d stall=%0d, expected 5 3", statWr, statStall);
    end
`endif
    tick();
    drop_req();
    for (int k = 1; k < 5; k++) serve_one("fill_order", addrs[k], datas[k], 4'hF, 32'h0);
    checks++;
    if (level !== 3'd0 || idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_drained: got level=%0d idle=%b, expected 0 1", level, idle);
    end
  endtask

  task automatic test_read_after_write();
    int waited;
    drive_req(32'h0300_0010, 32'h1111_1111, 4'hF);
    wait_ack("raw_w0_ack", waited);
    tick();
    drive_req(32'h0300_0014, 32'h2222_2222, 4'h3);
    wait_ack("raw_w1_ack", waited);
    tick();
    drive_req(32'h0300_0004, 32'h0, 4'h0);
    serve_one("raw_w0", 32'h0300_0010, 32'h1111_1111, 4'hF, 32'h0);
    checks++;
    if (mValid !== 1'b0 || sReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL raw_read_held: got mValid=%b sReady=%b, expected 0 0", mValid, sReady);
    end
    serve_one("raw_w1", 32'h0300_0014, 32'h2222_2222, 4'h3, 32'h0);
    serve_one("raw_read", 32'h0300_0004, 32'h0, 4'h0, 32'h1234_5678);
    checks++;
    if (sReady !== 1'b1 || sRdata !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL raw_resp: got sReady=%b rdata=%h, expected 1 12345678", sReady, sRdata);
    end
    tick();
    drop_req();
    checks++;
    if (sReady !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL raw_resp_pulse: got sReady=%b idle=%b, expected 0 1", sReady, idle);
    end
    drive_req(32'h0300_0018, 32'h3333_3333, 4'h1);
    wait_ack("raw_w2_ack", waited);
    tick();
    drop_req();
    serve_one("raw_w2", 32'h0300_0018, 32'h3333_3333, 4'h1, 32'hFFFF_FFFF);
    checks++;
    if (sRdata !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL raw_rdata_hold: got rdata=%h, expected 12345678", sRdata);
    end
  endtask

  task automatic test_read_empty();
    drive_req(32'h0300_0008, 32'h0, 4'h0);
    tick();
    checks++;
    if (sReady !== 1'b0 || mValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rd_wait: got sReady=%b mValid=%b, expected 0 0", sReady, mValid);
    end
    tick();
    checks++;
    if ({mValid, mAddr, mWstrb} !== {1'b1, 32'h0300_0008, 4'h0}) begin
      errors++;
      $display("[TB] FAIL rd_req: got v=%b addr=%h wstrb=%h, expected 1 03000008 0", mValid, mAddr, mWstrb);
    end
    tick();
    mReady = 1'b1; mRdata = 32'hCAFE_F00D;
    checks++;
    if (sReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rd_early: got sReady=%b at cycle 3, expected 0", sReady);
    end
    tick();
    mReady = 1'b0; mRdata = '0;
    checks++;
    if (sReady !== 1'b1 || sRdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("[TB] FAIL rd_latency: got sReady=%b rdata=%h at cycle 4, expected 1 cafef00d", sReady, sRdata);
    end
    tick();
    drop_req();
  endtask

  task automatic test_reset_mid_drain();
    int waited;
    for (int k = 0; k < 3; k++) begin
      drive_req(32'h0300_0200 + 32'(k * 4), 32'hB000_0000 + 32'(k), 4'hF);
      wait_ack("rst_fill_ack", waited);
      tick();
    end
    drop_req();
    checks++;
    if (level !== 3'd3 || mValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_pre: got level=%0d mValid=%b, expected 3 1", level, mValid);
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({sReady, sRdata, mValid, mAddr, mWdata, mWstrb} !== '0 || level !== 3'd0 || idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_async: got sReady=%b rdata=%h mValid=%b mAddr=%h level=%0d idle=%b, expected reset values",
               sReady, sRdata, mValid, mAddr, level, idle);
    end
    tick();
    rstN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (mValid !== 1'b0 || idle !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rst_no_stale: got mValid=%b idle=%b on cycle %0d, expected 0 1", mValid, idle, c);
      end
    end
    drive_req(32'h0300_0300, 32'h5555_AAAA, 4'hC);
    wait_ack("rst_fresh_ack", waited);
    tick();
    drop_req();
    serve_one("rst_fresh", 32'h0300_0300, 32'h5555_AAAA, 4'hC, 32'h0);
    checks++;
    if (level !== 3'd0 || idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_fresh_done: got level=%0d idle=%b, expected 0 1", level, idle);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill();
    test_read_after_write();
    test_read_empty();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
